// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction prefetch queue.
//   INSTR_BYTES   - byte stride between consecutive instruction fetches
//   fetch_state_e - fetch FSM states (FETCH: issuing, DRAIN: discarding stale responses)
//   ptr_width()   - FIFO pointer width for a given power-of-two depth
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   flush           - empties the FIFO at the next edge (wins over push/pop)
//   push, push_data - write an entry at the tail
//   pop             - drop the head entry (ignored when empty)
//   head_data       - current head entry (valid only when !empty)
//   count           - number of stored entries, 0..Depth
//   full, empty     - occupancy flags
module prefetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [Width-1:0]       push_data,
  input  logic                   pop,
  output logic [Width-1:0]       head_data,
  output logic [$clog2(Depth):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CntW'(Depth));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty && !flush;
  // Writing while full is only safe when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; head_data is only meaningful when !empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: instruction fetch stage with a request/response memory
// interface, a DEPTH-entry prefetch FIFO and branch redirect with stale-response drop.
// Ports:
//   clk, reset                       - clock, asynchronous active-high reset
//   imem_req_valid/ready/addr        - fetch request channel (word-aligned address)
//   imem_resp_valid/data             - in-order fetch responses (never back-pressured)
//   redirect_valid/pc                - single-cycle redirect; pc[1:0] ignored
//   instr_valid/ready/data/pc        - head of the prefetch FIFO towards decode
//   inflight                         - accepted requests still awaiting a response
// Optional feature, macro PREFETCH_PERF_EN: adds saturating 32-bit counters
//   perf_fetched (kept responses), perf_dropped (discarded responses) and
//   perf_stall (cycles with instr_ready && !instr_valid).
module instr_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned   XLEN     = 32,
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [AW-1:0]          imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [XLEN-1:0]        imem_resp_data,
  input  logic                   redirect_valid,
  input  logic [AW-1:0]          redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [XLEN-1:0]        instr_data,
  output logic [AW-1:0]          instr_pc,
  output logic [$clog2(DEPTH):0] inflight
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_dropped,
  output logic [31:0]            perf_stall
`endif
);

  localparam int unsigned   PtrW   = ptr_width(DEPTH);
  localparam int unsigned   CntW   = PtrW + 1;
  localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);
  localparam logic [AW-1:0] Step   = AW'(INSTR_BYTES);

  fetch_state_e    state_q, state_d;
  logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]   resp_pc_q, resp_pc_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CntW-1:0]      fifo_count;
  logic                 fifo_full, fifo_empty;
  logic [AW+XLEN-1:0]   fifo_head;
  logic [CntW:0]        credit_used;
  logic                 req_fire, resp_keep, instr_pop;
  logic [AW-1:0]        redirect_pc_aligned;
  logic                 unused_redirect_lsbs;

  assign redirect_pc_aligned  = {redirect_pc[AW-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Every request reserves a FIFO slot up front, so responses always find room.
  assign credit_used    = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign imem_req_valid = !reset && (state_q == FETCH) && (credit_used < DepthC) &&
                          !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response landing in the redirect cycle belongs to the old stream.
  assign resp_keep = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;

  assign instr_valid = !fifo_empty;
  assign instr_pop   = instr_valid && instr_ready;
  assign instr_pc    = instr_valid ? fifo_head[AW+XLEN-1:XLEN] : '0;
  assign instr_data  = instr_valid ? fifo_head[XLEN-1:0] : '0;
  assign inflight    = inflight_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_cnt_d = drop_cnt_q;
    inflight_d = inflight_q + CntW'(req_fire) - CntW'(imem_resp_valid);

    if (req_fire)  fetch_pc_d = fetch_pc_q + Step;
    if (resp_keep) resp_pc_d  = resp_pc_q + Step;
    if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CntW'(1);

    if ((state_q == DRAIN) && (drop_cnt_d == '0)) state_d = FETCH;

    // Everything still outstanding after this edge belongs to the old stream.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      drop_cnt_d = inflight_d;
      state_d    = (inflight_d != '0) ? DRAIN : FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  prefetch_fifo #(
    .Width (AW + XLEN),
    .Depth (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data ({resp_pc_q, imem_resp_data}),
    .pop       (instr_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The credit rule must make a push into a full FIFO without a pop impossible.
  push_on_full_a: assert property (@(posedge clk) disable iff (reset)
    !(resp_keep && fifo_full && !instr_pop));

`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_dropped_d = perf_dropped_q;
    perf_stall_d   = perf_stall_q;
    if (resp_keep && (perf_fetched_q != '1)) perf_fetched_d = perf_fetched_q + 32'd1;
    if (imem_resp_valid && !resp_keep && (perf_dropped_q != '1)) begin
      perf_dropped_d = perf_dropped_q + 32'd1;
    end
    if (instr_ready && !instr_valid && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue. A behavioural memory answers
// accepted requests in order after a programmable latency; a stream model
// (expected next PC, epoch-tagged outstanding requests, FIFO occupancy) checks
// every cycle, and directed/table sequences cover backpressure, redirect and wrap.
module tb_instr_prefetch_queue;

  localparam int unsigned   XLEN     = 32;
  localparam int unsigned   AW       = 32;
  localparam int unsigned   DEPTH    = 4;
  localparam logic [AW-1:0] RESET_PC = 32'h0;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   imem_req_valid;
  logic                   imem_req_ready = 1'b0;
  logic [AW-1:0]          imem_req_addr;
  logic                   imem_resp_valid = 1'b0;
  logic [XLEN-1:0]        imem_resp_data = '0;
  logic                   redirect_valid = 1'b0;
  logic [AW-1:0]          redirect_pc = '0;
  logic                   instr_valid;
  logic                   instr_ready = 1'b0;
  logic [XLEN-1:0]        instr_data;
  logic [AW-1:0]          instr_pc;
  logic [$clog2(DEPTH):0] inflight;
`ifdef PREFETCH_PERF_EN
  logic [31:0]            perf_fetched, perf_dropped, perf_stall;
`endif

  always #5 clk = ~clk;

  instr_prefetch_queue #(
    .XLEN     (XLEN),
    .AW       (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .inflight        (inflight)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_dropped    (perf_dropped),
    .perf_stall      (perf_stall)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            epoch;
    int            due;
  } mreq_t;

  typedef struct {
    logic [AW-1:0] rpc;
    int            lat;
    logic [AW-1:0] pc0;
    logic [AW-1:0] pc1;
    logic [AW-1:0] pc2;
  } vec_t;

  mreq_t         mq[$];
  logic [AW-1:0] dq[$];
  logic [AW-1:0] fetch_addr, exp_pc;
  int            cyc, cur_epoch, last_due, occ;
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_acc, max_inflight;
  int            g_lat_min = 1, g_lat_max = 1;
  bit            g_rr_rand = 1'b0, g_ir_rand = 1'b0, g_ir = 1'b1;
  int            sc_fetched, sc_dropped, sc_stall;

  function automatic logic [XLEN-1:0] mem_data(input logic [AW-1:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_dq(input string name, input int idx, input logic [AW-1:0] exp);
    if (idx < dq.size()) begin
      check(name, 64'(dq[idx]), 64'(exp));
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: only %0d instructions delivered, expected pc 0x%0h", name, dq.size(),
               exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    dq.delete();
    fetch_addr   = RESET_PC;
    exp_pc       = RESET_PC;
    cur_epoch    = 0;
    last_due     = 0;
    occ          = 0;
    cyc          = 0;
    n_acc        = 0;
    max_inflight = 0;
    sc_fetched   = 0;
    sc_dropped   = 0;
    sc_stall     = 0;
  endtask

  // Called just after a negedge; asserts reset mid-cycle and checks outputs at once.
  task automatic do_reset();
    #3;
    reset           = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    #1;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    check("rst_instr_data", 64'(instr_data), 64'd0);
`ifdef PREFETCH_PERF_EN
    check("rst_perf_fetched", 64'(perf_fetched), 64'd0);
    check("rst_perf_dropped", 64'(perf_dropped), 64'd0);
    check("rst_perf_stall", 64'(perf_stall), 64'd0);
`endif
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs after the negedge, check outputs, update the model.
  task automatic run_cycle(input logic rdir, input logic [AW-1:0] rpc);
    int qs, stale, due;
    bit resp, kept, deliver, exp_rv;
    qs    = mq.size();
    stale = 0;
    foreach (mq[i]) if (mq[i].epoch != cur_epoch) stale++;
    check("inflight", 64'(inflight), 64'(qs));
    if (int'(inflight) > max_inflight) max_inflight = int'(inflight);

    resp            = 1'b0;
    kept            = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (qs > 0 && mq[0].due <= cyc) begin
      resp            = 1'b1;
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_data(mq[0].addr);
      kept            = (mq[0].epoch == cur_epoch) && !rdir;
      void'(mq.pop_front());
    end
    imem_req_ready = g_rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    instr_ready    = g_ir_rand ? 1'($urandom_range(0, 1)) : g_ir;
    redirect_valid = rdir;
    redirect_pc    = rpc;
    #1;

    // Requests stop while old-stream responses remain, and whenever credits run out.
    exp_rv = (stale == 0) && (occ + qs < DEPTH) && !rdir;
    check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    check("req_addr", 64'(imem_req_addr), 64'(fetch_addr));
    check("instr_valid", 64'(instr_valid), 64'(occ > 0));

    deliver = (occ > 0) && instr_ready;
    if (deliver) begin
      check("instr_pc", 64'(instr_pc), 64'(exp_pc));
      check("instr_data", 64'(instr_data), 64'(mem_data(exp_pc)));
      dq.push_back(instr_pc);
      exp_pc = exp_pc + 32'd4;
    end

    if (imem_req_valid && imem_req_ready) begin
      due = cyc + $urandom_range(g_lat_min, g_lat_max);
      if (due < last_due) due = last_due;
      last_due = due;
      mq.push_back('{addr: imem_req_addr, epoch: cur_epoch, due: due});
      fetch_addr = fetch_addr + 32'd4;
      n_acc++;
    end

    if (resp) begin
      if (kept) sc_fetched++;
      else sc_dropped++;
    end
    if (instr_ready && occ == 0) sc_stall++;
    occ = occ + (kept ? 1 : 0) - (deliver ? 1 : 0);

    if (rdir) begin
      cur_epoch++;
      fetch_addr = {rpc[AW-1:2], 2'b00};
      exp_pc     = fetch_addr;
      occ        = 0;
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0);
  endtask

  vec_t vecs[4];
  int   bad;

  initial begin
    vecs[0] = '{rpc: 32'h0000_0103, lat: 1, pc0: 32'h0000_0100, pc1: 32'h0000_0104,
                pc2: 32'h0000_0108};
    vecs[1] = '{rpc: 32'h0000_2002, lat: 2, pc0: 32'h0000_2000, pc1: 32'h0000_2004,
                pc2: 32'h0000_2008};
    vecs[2] = '{rpc: 32'hFFFF_FFF8, lat: 1, pc0: 32'hFFFF_FFF8, pc1: 32'hFFFF_FFFC,
                pc2: 32'h0000_0000};
    vecs[3] = '{rpc: 32'hFFFF_FFFF, lat: 3, pc0: 32'hFFFF_FFFC, pc1: 32'h0000_0000,
                pc2: 32'h0000_0004};

    // Reset, 1-cycle memory, decode always ready.
    do_reset();
    g_lat_min = 1; g_lat_max = 1; g_ir = 1'b1;
    run_n(12);
    check_dq("seq_pc0", 0, 32'h0);
    check_dq("seq_pc1", 1, 32'h4);
    check_dq("seq_pc2", 2, 32'h8);
    check_dq("seq_pc3", 3, 32'hC);
    check("max_inflight_le_depth", 64'(max_inflight <= DEPTH), 64'd1);

    // Decode stalled for 20 cycles: exactly DEPTH requests, then resume at 0x10.
    do_reset();
    g_ir = 1'b0;
    run_n(20);
    check("stall_accepts", 64'(n_acc), 64'(DEPTH));
    check("stall_req_valid", 64'(imem_req_valid), 64'd0);
    check("stall_req_addr", 64'(imem_req_addr), 64'h10);
    g_ir = 1'b1;
    run_n(20);
    check_dq("resume_pc0", 0, 32'h0);
    check_dq("resume_pc3", 3, 32'hC);
    check_dq("resume_pc4", 4, 32'h10);
    check_dq("resume_pc5", 5, 32'h14);

    // Latency 3, redirect to 0x100 with two requests outstanding.
    do_reset();
    g_lat_min = 3; g_lat_max = 3;
    for (int i = 0; i < 20 && mq.size() != 2; i++) run_cycle(1'b0, '0);
    check("pre_redirect_inflight", 64'(inflight), 64'd2);
    run_cycle(1'b1, 32'h100);
    check("post_redirect_instr_valid", 64'(instr_valid), 64'd0);
    dq.delete();
    run_n(20);
    check_dq("redir_first_pc", 0, 32'h100);
    check_dq("redir_second_pc", 1, 32'h104);

    // Second redirect while the first is still draining.
    for (int i = 0; i < 20 && mq.size() < 3; i++) run_cycle(1'b0, '0);
    run_cycle(1'b1, 32'h100);
    run_cycle(1'b1, 32'h200);
    dq.delete();
    run_n(20);
    check_dq("redir2_first_pc", 0, 32'h200);
    bad = 0;
    foreach (dq[i]) if (dq[i] >= 32'h100 && dq[i] < 32'h200) bad++;
    check("redir2_no_stale_stream", 64'(bad), 64'd0);

    // Table of redirect targets: alignment and address wrap.
    do_reset();
    foreach (vecs[k]) begin
      g_lat_min = vecs[k].lat; g_lat_max = vecs[k].lat;
      run_n(3);
      run_cycle(1'b1, vecs[k].rpc);
      dq.delete();
      run_n(15);
      check_dq($sformatf("vec%0d_pc0", k), 0, vecs[k].pc0);
      check_dq($sformatf("vec%0d_pc1", k), 1, vecs[k].pc1);
      check_dq($sformatf("vec%0d_pc2", k), 2, vecs[k].pc2);
    end

    // Random request/decode readiness, random latency and occasional redirects.
    do_reset();
    g_rr_rand = 1'b1; g_ir_rand = 1'b1;
    g_lat_min = 1; g_lat_max = 4;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 24) == 0) run_cycle(1'b1, 32'($urandom));
      else run_cycle(1'b0, '0);
    end
    check("rand_max_inflight", 64'(max_inflight <= DEPTH), 64'd1);
`ifdef PREFETCH_PERF_EN
    check("perf_fetched", 64'(perf_fetched), 64'(sc_fetched));
    check("perf_dropped", 64'(perf_dropped), 64'(sc_dropped));
    check("perf_stall", 64'(perf_stall), 64'(sc_stall));
`endif

    // Asynchronous reset in the middle of a burst.
    g_rr_rand = 1'b0; g_ir_rand = 1'b0; g_ir = 1'b1;
    g_lat_min = 2; g_lat_max = 2;
    run_n(6);
    do_reset();
    run_n(10);
    check_dq("post_reset_pc0", 0, RESET_PC);
    check_dq("post_reset_pc1", 1, RESET_PC + 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
